// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit register between NREQ requesters.
// Optional owner lock is built in when REG_WRITE_ARB_LOCK_EN is defined.
module reg_write_arbiter #(
  parameter int unsigned       WIDTH   = 16,
  parameter int unsigned       NREQ    = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     wdata,
`ifdef REG_WRITE_ARB_LOCK_EN
  input  logic [NREQ-1:0]           lock,
`endif
  output logic [NREQ-1:0]           gnt,
  output logic [WIDTH-1:0]          reg_out,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int unsigned SelW = $clog2(NREQ);
  typedef logic [SelW-1:0] sel_t;

`ifdef REG_WRITE_ARB_LOCK_EN
  typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;
`else
  typedef enum logic [0:0] {StIdle, StGrant} state_e;
`endif

  state_e           state_q, state_d;
  sel_t             sel_q, sel_d;
  sel_t             rr_ptr_q, rr_ptr_d;
  sel_t             owner_q, owner_d;
  logic [WIDTH-1:0] reg_q, reg_d;

  logic [WIDTH-1:0] wdata_arr [NREQ];
  sel_t             cand;
  sel_t             pick_idx;
  logic             pick_valid;
  logic             commit;

  for (genvar g = 0; g < NREQ; g++) begin : gen_wdata
    assign wdata_arr[g] = wdata[g*WIDTH +: WIDTH];
  end

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = sel_t'((32'(rr_ptr_q) + i) % NREQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // A GRANT cycle only writes if the selected requester is still asking.
  assign commit = (state_q == StGrant) && req[sel_q];

  always_comb begin
    gnt = '0;
    if (rst && commit) begin
      gnt[sel_q] = 1'b1;
    end
  end

  assign busy    = (state_q == StGrant);
  assign reg_out = reg_q;
  assign owner   = owner_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    reg_d    = reg_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        state_d = StIdle;
        if (commit) begin
          reg_d    = wdata_arr[sel_q];
          owner_d  = sel_q;
          rr_ptr_d = (sel_q == sel_t'(NREQ - 1)) ? '0 : sel_q + sel_t'(1);
`ifdef REG_WRITE_ARB_LOCK_EN
          if (lock[sel_q]) begin
            state_d = StLocked;
          end
`endif
        end
      end
`ifdef REG_WRITE_ARB_LOCK_EN
      StLocked: begin
        // Only the lock holder may be granted; releasing the lock costs one idle cycle.
        if (!lock[sel_q]) begin
          state_d = StIdle;
        end else if (req[sel_q]) begin
          state_d = StGrant;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      reg_q    <= RST_VAL;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      reg_q    <= reg_d;
    end
  end

endmodule
